// File: rtl/alu_pkg.sv
// Purpose: shared ALU control codes and FSM state encodings for the execute stage.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// The ALU control decoder uses the same codes, so each code value is defined once, here.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;

    // FSM state encodings, kept as plain constants for compatibility with older code.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    function automatic logic is_shift_op(input logic [2:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Purpose: combinational ADD/SUB/AND/OR with signed-overflow detection.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the output follows the inputs.
//
// Ports:
//   alu_ctrl  3-bit ALU code; 110/111 and the shift codes evaluate as ADD
//   op_a      first operand
//   op_b      second operand
//   result    ADD/SUB (modulo 2^WIDTH), AND or OR result
//   overflow  signed overflow for ADD/SUB, 0 for AND/OR
module alu_logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    always_comb begin
        result   = sum;
        overflow = 1'b0;
        case (alu_ctrl)
            ALU_SUB: begin
                result   = diff;
                // Operands of opposite sign whose difference flips away from op_a's sign.
                overflow = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                           (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            default: begin
                // ADD, plus the unused codes which alias to ADD.
                result   = sum;
                overflow = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                           (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Purpose: execute-stage ALU; single-cycle logic/arith ops, iterative 1-bit-per-cycle shifts.
// Latency: 1 cycle for ADD/SUB/AND/OR and zero-amount shifts; shamt+1 cycles for shifts.
// Backpressure: busy is high while a shift iterates; start is ignored then (no queuing).
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (aborts any shift in flight)
//   start     request, accepted only in IDLE
//   alu_ctrl  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SRL (110/111 act as ADD)
//   op_a      first operand
//   op_b      second operand, also the value shifted for SLL/SRL
//   shamt     unsigned shift amount
//   busy      high while a shift iterates
//   done      one-cycle pulse when result/zero/overflow have just been updated
//   result    registered result, held until the next completion
//   zero      registered (result == 0)
//   overflow  registered signed overflow (ADD/SUB only)
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    logic [0:0]       state;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic             shift_left;

    logic [WIDTH-1:0] lu_result;
    logic             lu_overflow;
    logic             start_shift;
    logic [WIDTH-1:0] imm_result;
    logic             imm_overflow;
    logic [WIDTH-1:0] work_next;

    alu_logic_unit #(
        .WIDTH (WIDTH)
    ) u_logic (
        .alu_ctrl (alu_ctrl),
        .op_a     (op_a),
        .op_b     (op_b),
        .result   (lu_result),
        .overflow (lu_overflow)
    );

    // Only non-zero shifts go multicycle; a zero-amount shift completes like a logic op.
    assign start_shift = is_shift_op(alu_ctrl) && (shamt != '0);

    always_comb begin
        imm_result   = lu_result;
        imm_overflow = lu_overflow;
        if (is_shift_op(alu_ctrl)) begin
            imm_result   = op_b;
            imm_overflow = 1'b0;
        end
    end

    assign work_next = shift_left ? {work[WIDTH-2:0], 1'b0}
                                  : {1'b0, work[WIDTH-1:1]};

    assign busy = (state == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            work       <= '0;
            cnt        <= '0;
            shift_left <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            zero       <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (start_shift) begin
                            work       <= op_b;
                            cnt        <= shamt;
                            shift_left <= (alu_ctrl == ALU_SLL);
                            state      <= ST_SHIFT;
                        end else begin
                            result   <= imm_result;
                            zero     <= (imm_result == '0);
                            overflow <= imm_overflow;
                            done     <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt - 1'b1;
                    // Last iteration: publish the shifted value in the same edge.
                    if (cnt == SHW'(1)) begin
                        result   <= work_next;
                        zero     <= (work_next == '0);
                        overflow <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] last_res;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .alu_ctrl (alu_ctrl),
        .op_a     (op_a),
        .op_b     (op_b),
        .shamt    (shamt),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operation's meaning.
    function automatic logic [31:0] model_res(input logic [2:0] c, input logic [31:0] a,
                                              input logic [31:0] b, input int sh);
        case (c)
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return b << sh;
            3'd5:    return b >> sh;
            default: return a + b;
        endcase
    endfunction

    function automatic logic model_ovf(input logic [2:0] c, input logic [31:0] a,
                                       input logic [31:0] b);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (c == 3'd2 || c == 3'd3 || c == 3'd4 || c == 3'd5) return 1'b0;
        s = (c == 3'd1) ? sa - sb : sa + sb;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic int model_lat(input logic [2:0] c, input int sh);
        if ((c == 3'd4 || c == 3'd5) && sh != 0) return sh + 1;
        return 1;
    endfunction

    // Issue one op, scramble inputs after acceptance, wait for done within a budget.
    // If inject > 0, an ADD start is pulsed at that cycle of the wait (must be ignored).
    task automatic run_op(input string tag, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input int inject);
        logic [31:0] er;
        logic        eo;
        int          el, lat, busy_n;
        er = model_res(c, a, b, int'(sh));
        eo = model_ovf(c, a, b);
        el = model_lat(c, int'(sh));
        start = 1'b1; alu_ctrl = c; op_a = a; op_b = b; shamt = sh;
        @(posedge clk); #1;
        start = 1'b0;
        alu_ctrl = 3'($urandom); op_a = $urandom; op_b = $urandom; shamt = 5'($urandom);
        lat = 1;
        busy_n = 0;
        while (!done && lat < 64) begin
            if (busy) busy_n++;
            check({tag, ".held"}, result, last_res);
            if (lat == inject) begin
                start = 1'b1; alu_ctrl = 3'd0; op_a = 32'h1; op_b = 32'h1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, ".done"}, done, 1);
        check({tag, ".lat"}, lat, el);
        check({tag, ".busycyc"}, busy_n, el - 1);
        check({tag, ".busy_at_done"}, busy, 0);
        check({tag, ".result"}, result, er);
        check({tag, ".zero"}, zero, (er == 0));
        check({tag, ".ovf"}, overflow, eo);
        last_res = er;
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".hold"}, result, er);
    endtask

    initial begin
        int saw_done;
        rst = 1'b1; start = 1'b0; alu_ctrl = 3'd0; op_a = '0; op_b = '0; shamt = '0;
        last_res = 32'h0;

        // 1: reset held two cycles
        @(posedge clk); @(posedge clk); #1;
        check("rst.result", result, 0);
        check("rst.zero", zero, 1);
        check("rst.ovf", overflow, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 2-3: arithmetic corner cases
        run_op("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0);
        run_op("sub_zero", 3'd1, 32'd5, 32'd5, 5'd0, 0);
        run_op("sub_ovf", 3'd1, 32'h8000_0000, 32'h0000_0001, 5'd0, 0);

        // 4: long SLL with an ignored ADD start mid-shift
        run_op("sll31", 3'd4, 32'h0, 32'h0000_0001, 5'd31, 10);

        // 5: SRL zero fill, zero-amount shift
        run_op("srl4", 3'd5, 32'h0, 32'h8000_0000, 5'd4, 0);
        run_op("srl0", 3'd5, 32'h0, 32'hDEAD_BEEF, 5'd0, 0);

        // 6: reset during the third busy cycle of an SLL by 10
        start = 1'b1; alu_ctrl = 3'd4; op_b = 32'h0000_00FF; shamt = 5'd10;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort.busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.busy", busy, 0);
        check("abort.result", result, 0);
        check("abort.zero", zero, 1);
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) saw_done++;
            @(posedge clk); #1;
        end
        check("abort.no_done", saw_done, 0);
        last_res = 32'h0;

        // 6: back-to-back, AND started during the ADD's done cycle
        start = 1'b1; alu_ctrl = 3'd0; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk); #1;
        check("b2b.add_done", done, 1);
        check("b2b.add_res", result, 32'd7);
        alu_ctrl = 3'd2; op_a = 32'hF0F0_F0F0; op_b = 32'hFF00_FF00;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b.and_done", done, 1);
        check("b2b.and_res", result, 32'hF000_F000);
        @(posedge clk); #1;
        check("b2b.pulse", done, 0);
        last_res = 32'hF000_F000;

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  rc;
            logic [31:0] ra, rb;
            logic [4:0]  rs;
            rc = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            if (n % 5 == 0) rb = ra;
            rs = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            run_op("rand", rc, ra, rb, rs, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
